attr_colour_pipe: RTL and testbench
===================================

Name: attr_colour_pipe

Overview:
- Next-generation text-mode attribute decoder for the VGA text controller. Sits between the character/attribute fetch stage and the pixel output.
- Takes an 8-bit attribute byte and the glyph pixel bit and produces the final pixel colour.
- Palette is a 16-entry CPU-writable register file, replacing the fixed colour table.
- Adds frame-based blink timing, a bright-background mode and cursor inversion, delivered through a 2-stage valid pipeline.

Parameters:
- COLOR_W, 16, palette entry/pixel colour width; legal range 16..24.
- BLINK_FRAMES, 16, frame ticks per blink half-period; must be >= 1.
- CNT_W, $clog2(BLINK_FRAMES), blink frame counter width (derived; do not override).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  pixel input qualifier
- i_attr  in  8  attribute byte: [3:0] foreground index, [6:4] background index, [7] blink/bright bit
- i_pixel_on  in  1  glyph bit: 1 = foreground, 0 = background
- i_cursor  in  1  pixel lies inside the cursor cell region
- i_frame_tick  in  1  one-cycle pulse per frame (vsync start)
- i_blink_en  in  1  1 = attr[7] is blink; 0 = attr[7] is background intensity bit
- i_pal_we  in  1  palette write strobe
- i_pal_addr  in  4  palette write index
- i_pal_wdata  in  COLOR_W  palette write data
- o_valid  out  1  output pixel qualifier
- o_rgb  out  COLOR_W  output pixel colour
- o_blink_phase  out  1  current blink phase (1 = blinking text hidden, cursor shown)

Behaviour:
- Reset (async, while i_rst_n = 0): o_valid = 0, o_rgb = 0, o_blink_phase = 0, frame counter = 0, pipeline valid bits cleared.
- Reset palette: CGA defaults, indices 0..F = 0000, 0015, 0540, 0555, A800, A815, AAA0, AD55, 52AA, 52BF, 57EA, 57FF, FAAA, FABF, FFEA, FFFF. Each 16-bit value is left-aligned in COLOR_W; the low COLOR_W-16 bits are 0.
- Palette write: on a rising edge with i_pal_we = 1, entry[i_pal_addr] <= i_pal_wdata. Writes are accepted regardless of i_valid.
- Read/write collision: stage 1 sees the pre-write (old) value.
- Blink timer: on each i_frame_tick the counter increments. When the counter reaches BLINK_FRAMES-1 and a tick arrives, the counter wraps to 0 and o_blink_phase toggles. Non-tick cycles hold state. Full blink period = 2*BLINK_FRAMES ticks.
- Stage 1 (registered, captured when i_valid = 1):
  - fg_col = palette[attr[3:0]].
  - bg index = {attr[7] & ~i_blink_en, attr[6:4]}.
  - bg_col = palette[bg index].
  - Register pixel_on, cursor, hide = attr[7] & i_blink_en & blink_phase.
  - v1 <= i_valid.
- Stage 2 (registered):
  - sel_fg = pixel_on & ~hide.
  - If cursor & blink_phase, sel_fg is inverted.
  - o_rgb <= sel_fg ? fg_col : bg_col.
  - o_valid <= v1.
- Latency: exactly 2 cycles from i_valid to o_valid. Throughput is 1 pixel/cycle with no stalls.
- When i_valid = 0, stage data registers hold their values; only the valid bits propagate.
- blink_phase is sampled in stage 1. A toggle on the same edge therefore affects pixels entering from the next cycle.
- Reset mid-stream: in-flight pixels are discarded (o_valid = 0 on the next edge after release). The palette returns to defaults.

Decomposition:
- Shared package vga_text_pkg:
  - CGA_DEFAULT_PAL (16 x 16-bit constant array)
  - attribute field index localparams (FG_LSB/MSB, BG_LSB/MSB, BLINK_BIT)
- One natural sub-module: attr_palette_regfile, a 16 x COLOR_W register file with one write port, two asynchronous read ports and async reset to the defaults.

Test Plan:
- Reset defaults, BLINK_FRAMES = 2: after reset, i_valid = 1, i_attr = 8'h1E, pixel_on = 1 -> o_rgb = FFEA two cycles later, o_valid = 1. Same input with pixel_on = 0 -> 0015.
- Palette write: pal_we, addr 4, wdata 1234; next cycle attr = 8'h04, pixel_on = 1 -> o_rgb = 1234. Same-cycle write plus read of entry 4 -> old value A800.
- Blink timing: i_blink_en = 1, attr = 8'h87, pixel_on = 1.
  - Ticks 1-2 -> phase toggles to 1 after the 2nd tick.
  - While phase = 1, o_rgb = 0000 (bg).
  - After ticks 3-4, phase = 0 and o_rgb = AD55.
- Bright background: i_blink_en = 0, attr = 8'hC0, pixel_on = 0 -> o_rgb = FAAA (index C); no hiding in either phase.
- Cursor inversion: phase = 1, i_cursor = 1, attr = 8'h07, pixel_on = 0 -> AD55; pixel_on = 1 -> 0000. With phase = 0 the colours are not inverted.
- Async reset mid-stream: assert i_rst_n = 0 between edges with two pixels in flight -> o_valid = 0 immediately and stays 0 for 2 cycles after release. A previously written entry 4 reads back A800.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared constants for the VGA text attribute path: attribute field positions,
// palette geometry and the CGA default colour table (16-bit, index 0 first).
package vga_text_pkg;

  localparam int unsigned ATTR_W    = 8;
  localparam int unsigned PAL_DEPTH = 16;
  localparam int unsigned PAL_AW    = 4;
  localparam int unsigned CGA_W     = 16;

  localparam int unsigned FG_LSB    = 0;
  localparam int unsigned FG_MSB    = 3;
  localparam int unsigned BG_LSB    = 4;
  localparam int unsigned BG_MSB    = 6;
  localparam int unsigned BLINK_BIT = 7;

  // Packed so that CGA_DEFAULT_PAL[i] is entry i; listed here from index F down to 0.
  localparam logic [PAL_DEPTH-1:0][CGA_W-1:0] CGA_DEFAULT_PAL = {
    16'hFFFF, 16'hFFEA, 16'hFABF, 16'hFAAA,
    16'h57FF, 16'h57EA, 16'h52BF, 16'h52AA,
    16'hAD55, 16'hAAA0, 16'hA815, 16'hA800,
    16'h0555, 16'h0540, 16'h0015, 16'h0000
  };

endpackage

// File: rtl/attr_colour_pipe_if.sv
// Pixel/attribute and palette-write bundle for attr_colour_pipe.
// master: fetch stage / CPU side (drives i_*), slave: the colour pipe (drives o_*).
interface attr_colour_pipe_if #(
  parameter int unsigned COLOR_W = 16
);
  import vga_text_pkg::*;

  logic                i_valid;
  logic [ATTR_W-1:0]   i_attr;
  logic                i_pixel_on;
  logic                i_cursor;
  logic                i_frame_tick;
  logic                i_blink_en;
  logic                i_pal_we;
  logic [PAL_AW-1:0]   i_pal_addr;
  logic [COLOR_W-1:0]  i_pal_wdata;
  logic                o_valid;
  logic [COLOR_W-1:0]  o_rgb;
  logic                o_blink_phase;

  modport master (
    output i_valid, i_attr, i_pixel_on, i_cursor, i_frame_tick, i_blink_en,
           i_pal_we, i_pal_addr, i_pal_wdata,
    input  o_valid, o_rgb, o_blink_phase
  );

  modport slave (
    input  i_valid, i_attr, i_pixel_on, i_cursor, i_frame_tick, i_blink_en,
           i_pal_we, i_pal_addr, i_pal_wdata,
    output o_valid, o_rgb, o_blink_phase
  );

endinterface

// File: rtl/attr_palette_regfile.sv
// 16 x COLOR_W palette: one synchronous write port, two asynchronous read ports,
// async reset to the CGA defaults left-aligned in COLOR_W.
// Ports: clk, rst_n, we/waddr/wdata (write), rd_a_addr/rd_a_data, rd_b_addr/rd_b_data.
module attr_palette_regfile
  import vga_text_pkg::*;
#(
  parameter int unsigned COLOR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [PAL_AW-1:0]  waddr,
  input  logic [COLOR_W-1:0] wdata,
  input  logic [PAL_AW-1:0]  rd_a_addr,
  output logic [COLOR_W-1:0] rd_a_data,
  input  logic [PAL_AW-1:0]  rd_b_addr,
  output logic [COLOR_W-1:0] rd_b_data
);

  logic [PAL_DEPTH-1:0][COLOR_W-1:0] pal_q, pal_d;

  function automatic logic [COLOR_W-1:0] default_entry(input logic [PAL_AW-1:0] idx);
    return COLOR_W'(CGA_DEFAULT_PAL[idx]) << (COLOR_W - CGA_W);
  endfunction

  // Write port
  always_comb begin
    pal_d = pal_q;
    if (we) pal_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(PAL_DEPTH); i++) pal_q[i] <= default_entry(PAL_AW'(i));
    end else begin
      pal_q <= pal_d;
    end
  end

  // Reads see the registered contents, so a same-edge write is not visible yet.
  assign rd_a_data = pal_q[rd_a_addr];
  assign rd_b_data = pal_q[rd_b_addr];

endmodule

// File: rtl/attr_colour_pipe.sv
// Text-mode attribute decoder: palette lookup, blink timing, bright background and
// cursor inversion in a 2-stage valid pipeline (latency 2, 1 pixel/cycle).
// Ports: i_clk, i_rst_n (async active-low), bus (attr_colour_pipe_if.slave):
//   pixel in (i_valid/i_attr/i_pixel_on/i_cursor), i_frame_tick, i_blink_en,
//   palette write (i_pal_we/i_pal_addr/i_pal_wdata), o_valid/o_rgb/o_blink_phase.
module attr_colour_pipe
  import vga_text_pkg::*;
#(
  parameter int unsigned COLOR_W      = 16,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  attr_colour_pipe_if.slave  bus
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic               v1_q, v1_d, v2_q, v2_d;
  logic [COLOR_W-1:0] fg_q, fg_d, bg_q, bg_d, rgb_q, rgb_d;
  logic               pon_q, pon_d, hide_q, hide_d, inv_q, inv_d;

  logic [PAL_AW-1:0]  fg_idx_c, bg_idx_c;
  logic [COLOR_W-1:0] fg_col_c, bg_col_c;
  logic               sel_fg_c;

  // With blink disabled, attr[7] becomes the background intensity bit.
  assign fg_idx_c = bus.i_attr[FG_MSB:FG_LSB];
  assign bg_idx_c = {bus.i_attr[BLINK_BIT] & ~bus.i_blink_en, bus.i_attr[BG_MSB:BG_LSB]};

  attr_palette_regfile #(.COLOR_W(COLOR_W)) u_pal (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .we        (bus.i_pal_we),
    .waddr     (bus.i_pal_addr),
    .wdata     (bus.i_pal_wdata),
    .rd_a_addr (fg_idx_c),
    .rd_a_data (fg_col_c),
    .rd_b_addr (bg_idx_c),
    .rd_b_data (bg_col_c)
  );

  // Cursor flips the fg/bg choice during the visible blink phase.
  assign sel_fg_c = (pon_q & ~hide_q) ^ inv_q;

  // Next-state: blink timer, stage 1 capture, stage 2 colour select.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    v1_d    = bus.i_valid;
    fg_d    = fg_q;
    bg_d    = bg_q;
    pon_d   = pon_q;
    hide_d  = hide_q;
    inv_d   = inv_q;
    v2_d    = v1_q;
    rgb_d   = rgb_q;

    if (bus.i_frame_tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (bus.i_valid) begin
      fg_d   = fg_col_c;
      bg_d   = bg_col_c;
      pon_d  = bus.i_pixel_on;
      hide_d = bus.i_attr[BLINK_BIT] & bus.i_blink_en & phase_q;
      inv_d  = bus.i_cursor & phase_q;
    end

    if (v1_q) rgb_d = sel_fg_c ? fg_q : bg_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      v1_q    <= 1'b0;
      fg_q    <= '0;
      bg_q    <= '0;
      pon_q   <= 1'b0;
      hide_q  <= 1'b0;
      inv_q   <= 1'b0;
      v2_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      v1_q    <= v1_d;
      fg_q    <= fg_d;
      bg_q    <= bg_d;
      pon_q   <= pon_d;
      hide_q  <= hide_d;
      inv_q   <= inv_d;
      v2_q    <= v2_d;
      rgb_q   <= rgb_d;
    end
  end

  assign bus.o_valid       = v2_q;
  assign bus.o_rgb         = rgb_q;
  assign bus.o_blink_phase = phase_q;

endmodule

// File: tb/tb_attr_colour_pipe.sv
// Bench for attr_colour_pipe (COLOR_W=16, BLINK_FRAMES=2): directed scenarios
// plus random traffic, all checked against a behavioural colour model.
module tb_attr_colour_pipe;

  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  attr_colour_pipe_if #(.COLOR_W(16)) bus ();

  attr_colour_pipe #(.COLOR_W(16), .BLINK_FRAMES(BF)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] def_pal [16];
  logic [15:0] pal_m   [16];
  int          tick_m;
  bit          phase_m;
  bit          s1_v, out_v;
  logic [15:0] s1_rgb, out_rgb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pal_m[i] = def_pal[i];
    tick_m  = 0;
    phase_m = 1'b0;
    s1_v    = 1'b0;
    out_v   = 1'b0;
    s1_rgb  = '0;
    out_rgb = '0;
  endtask

  task automatic drive(input bit v, input logic [7:0] attr, input bit pon, input bit cur,
                       input bit tick, input bit ben, input bit we,
                       input logic [3:0] addr, input logic [15:0] wd);
    bus.i_valid      = v;
    bus.i_attr       = attr;
    bus.i_pixel_on   = pon;
    bus.i_cursor     = cur;
    bus.i_frame_tick = tick;
    bus.i_blink_en   = ben;
    bus.i_pal_we     = we;
    bus.i_pal_addr   = addr;
    bus.i_pal_wdata  = wd;
  endtask

  task automatic idle();
    drive(0, 8'h00, 0, 0, 0, 0, 0, 4'h0, 16'h0);
  endtask

  // Colour the spec's rules produce for the pixel currently on the inputs.
  function automatic logic [15:0] expect_colour();
    logic [7:0] a;
    logic [3:0] bgi;
    bit blink_attr, show_fg;
    a          = bus.i_attr;
    blink_attr = a[7] && bus.i_blink_en;
    bgi        = {a[7] && !bus.i_blink_en, a[6:4]};
    show_fg    = bus.i_pixel_on && !(blink_attr && phase_m);
    if (bus.i_cursor && phase_m) show_fg = !show_fg;
    return show_fg ? pal_m[a[3:0]] : pal_m[bgi];
  endfunction

  // One clock: advance model across the edge and compare all outputs.
  task automatic step();
    logic [15:0] px;
    bit nv, we, tk;
    logic [3:0] wa;
    logic [15:0] wd;
    px = expect_colour();
    nv = bus.i_valid;
    we = bus.i_pal_we;
    wa = bus.i_pal_addr;
    wd = bus.i_pal_wdata;
    tk = bus.i_frame_tick;
    @(posedge clk);
    if (we) pal_m[wa] = wd;
    if (tk) begin
      tick_m++;
      if (tick_m == BF) begin
        tick_m  = 0;
        phase_m = !phase_m;
      end
    end
    out_v = s1_v;
    if (s1_v) out_rgb = s1_rgb;
    s1_v = nv;
    if (nv) s1_rgb = px;
    #1;
    check("o_valid", 32'(bus.o_valid), 32'(out_v));
    check("o_rgb", 32'(bus.o_rgb), 32'(out_rgb));
    check("o_blink_phase", 32'(bus.o_blink_phase), 32'(phase_m));
  endtask

  // Single pixel followed by an idle cycle, so it is on the output afterwards.
  task automatic pix(input logic [7:0] attr, input bit pon, input bit cur, input bit ben);
    drive(1, attr, pon, cur, 0, ben, 0, 4'h0, 16'h0);
    step();
    idle();
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 8'h00, 0, 0, 1, 0, 0, 4'h0, 16'h0);
      step();
    end
    idle();
  endtask

  // Asynchronous reset asserted between edges, released on the falling edge.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_o_valid", 32'(bus.o_valid), 32'h0);
    check("rst_o_rgb", 32'(bus.o_rgb), 32'h0);
    check("rst_phase", 32'(bus.o_blink_phase), 32'h0);
    model_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    def_pal = '{16'h0000, 16'h0015, 16'h0540, 16'h0555, 16'hA800, 16'hA815, 16'hAAA0, 16'hAD55,
                16'h52AA, 16'h52BF, 16'h57EA, 16'h57FF, 16'hFAAA, 16'hFABF, 16'hFFEA, 16'hFFFF};
    model_reset();
    idle();
    @(negedge clk);
    @(negedge clk);
    check("reset_o_valid", 32'(bus.o_valid), 32'h0);
    check("reset_o_rgb", 32'(bus.o_rgb), 32'h0);
    rst_n = 1'b1;

    // Default palette, foreground and background
    pix(8'h1E, 1, 0, 0);
    check("def_fg", 32'(bus.o_rgb), 32'hFFEA);
    pix(8'h1E, 0, 0, 0);
    check("def_bg", 32'(bus.o_rgb), 32'h0015);

    // Write colliding with a read of the same entry returns the old value
    drive(1, 8'h04, 1, 0, 0, 0, 1, 4'h4, 16'h1234);
    step();
    idle();
    step();
    check("collide_old", 32'(bus.o_rgb), 32'hA800);
    pix(8'h04, 1, 0, 0);
    check("pal_write", 32'(bus.o_rgb), 32'h1234);

    // Blink timing
    ticks(1);
    check("phase_tick1", 32'(bus.o_blink_phase), 32'h0);
    ticks(1);
    check("phase_tick2", 32'(bus.o_blink_phase), 32'h1);
    pix(8'h87, 1, 0, 1);
    check("blink_hidden", 32'(bus.o_rgb), 32'h0000);
    ticks(2);
    check("phase_tick4", 32'(bus.o_blink_phase), 32'h0);
    pix(8'h87, 1, 0, 1);
    check("blink_shown", 32'(bus.o_rgb), 32'hAD55);

    // Bright background, both phases
    pix(8'hC0, 0, 0, 0);
    check("bright_ph0", 32'(bus.o_rgb), 32'hFAAA);
    ticks(2);
    pix(8'hC0, 0, 0, 0);
    check("bright_ph1", 32'(bus.o_rgb), 32'hFAAA);

    // Cursor inversion (phase is 1 here)
    pix(8'h07, 0, 1, 0);
    check("cursor_inv_bg", 32'(bus.o_rgb), 32'hAD55);
    pix(8'h07, 1, 1, 0);
    check("cursor_inv_fg", 32'(bus.o_rgb), 32'h0000);
    ticks(2);
    pix(8'h07, 0, 1, 0);
    check("cursor_ph0_bg", 32'(bus.o_rgb), 32'h0000);
    pix(8'h07, 1, 1, 0);
    check("cursor_ph0_fg", 32'(bus.o_rgb), 32'hAD55);

    // Reset with two pixels in flight, palette back to defaults
    drive(1, 8'h00, 0, 0, 0, 0, 1, 4'h4, 16'h1234);
    step();
    drive(1, 8'h0F, 1, 0, 0, 0, 0, 4'h0, 16'h0);
    step();
    mid_reset();
    step();
    step();
    pix(8'h04, 1, 0, 0);
    check("reset_pal4", 32'(bus.o_rgb), 32'hA800);

    // Random traffic, with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 7) == 0,
            4'($urandom), 16'($urandom));
      step();
      if (i == 200) mid_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
